// File: rtl/axil_bram_ctrl.sv
// axil_bram_ctrl: AXI4-Lite slave giving word access to one bram port.
// Ports: clk/rst_n, AXI-Lite AW/W/B/AR/R (s_*), bram port command/data (bram_*).
module axil_bram_ctrl #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = ADDR_WIDTH + 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic                      bram_en,
    output logic                      bram_we,
    output logic [DATA_WIDTH/8-1:0]   bram_wstrb,
    output logic [ADDR_WIDTH-1:0]     bram_addr,
    output logic [DATA_WIDTH-1:0]     bram_din,
    input  logic [DATA_WIDTH-1:0]     bram_dout
);

    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        WR_RESP,
        RD_WAIT,
        RD_RESP
    } state_t;

    state_t                state;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [SW-1:0]         w_strb;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic wr_go;
    logic wr_soon;

    // Byte-lane bits of the AXI addresses carry no information here.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{s_awaddr[1:0], s_araddr[1:0]};

    assign s_awready = !aw_held;
    assign s_wready  = !w_held;
    assign s_bresp   = 2'b00;
    assign s_rresp   = 2'b00;

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign wr_go = (state == IDLE) && aw_held && w_held;

    // A write that completes its AW/W pair this cycle wins over a
    // simultaneous AR, so the read is held off until the write is issued.
    assign wr_soon   = (aw_held || s_awvalid) && (w_held || s_wvalid);
    assign s_arready = (state == IDLE) && !wr_soon;
    assign ar_hs     = s_arvalid && s_arready;

    always_comb begin
        bram_en    = 1'b0;
        bram_we    = 1'b0;
        bram_wstrb = '0;
        bram_addr  = '0;
        bram_din   = '0;
        if (wr_go) begin
            bram_en    = 1'b1;
            bram_we    = 1'b1;
            bram_wstrb = w_strb;
            bram_addr  = aw_addr;
            bram_din   = w_data;
        end else if (ar_hs) begin
            bram_en   = 1'b1;
            bram_addr = s_araddr[ADDR_WIDTH+1:2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held <= 1'b0;
            aw_addr <= '0;
            w_held  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_addr <= s_awaddr[ADDR_WIDTH+1:2];
            end else if (wr_go) begin
                aw_held <= 1'b0;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_wdata;
                w_strb <= s_wstrb;
            end else if (wr_go) begin
                w_held <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s_bvalid <= 1'b0;
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (wr_go) begin
                        s_bvalid <= 1'b1;
                        state    <= WR_RESP;
                    end else if (ar_hs) begin
                        state <= RD_WAIT;
                    end
                end
                WR_RESP: begin
                    if (s_bready) begin
                        s_bvalid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RD_WAIT: begin
                    s_rdata  <= bram_dout;
                    s_rvalid <= 1'b1;
                    state    <= RD_RESP;
                end
                RD_RESP: begin
                    if (s_rready) begin
                        s_rvalid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_bram_ctrl.sv
// tb_axil_bram_ctrl: directed stimulus with a queue-based scoreboard.
// Ports: none; drives axil_bram_ctrl and models the attached bram port.
module tb_axil_bram_ctrl;

    logic        clk;
    logic        rst_n;
    logic [11:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [11:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        bram_en;
    logic        bram_we;
    logic [3:0]  bram_wstrb;
    logic [9:0]  bram_addr;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;

    axil_bram_ctrl #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_wstrb(bram_wstrb),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout)
    );

    typedef struct packed {
        logic        we;
        logic [9:0]  addr;
        logic [3:0]  strb;
        logic [31:0] din;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [1:0]  b_q[$];
    logic [31:0] r_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] mem [1024];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bram port model: one-cycle synchronous read, byte-strobed write
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) begin
                for (int i = 0; i < 4; i++)
                    if (bram_wstrb[i])
                        mem[bram_addr][8*i +: 8] <= bram_din[8*i +: 8];
            end else begin
                bram_dout <= mem[bram_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents something.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bram_en) begin
                if (cmd_q.size() == 0) begin
                    chk("bram_unexpected", 32'(cmd_q.size()), 32'd1);
                end else begin
                    cmd_t e;
                    e = cmd_q.pop_front();
                    chk("bram_we", {31'd0, bram_we}, {31'd0, e.we});
                    chk("bram_addr", {22'd0, bram_addr}, {22'd0, e.addr});
                    if (e.we) begin
                        chk("bram_wstrb", {28'd0, bram_wstrb}, {28'd0, e.strb});
                        chk("bram_din", bram_din, e.din);
                    end
                end
            end
            if (s_bvalid && s_bready) begin
                if (b_q.size() == 0)
                    chk("b_unexpected", 32'(b_q.size()), 32'd1);
                else
                    chk("bresp", {30'd0, s_bresp}, {30'd0, b_q.pop_front()});
            end
            if (s_rvalid && s_rready) begin
                if (r_q.size() == 0) begin
                    chk("r_unexpected", 32'(r_q.size()), 32'd1);
                end else begin
                    chk("rdata", s_rdata, r_q.pop_front());
                    chk("rresp", {30'd0, s_rresp}, 32'd0);
                end
            end
        end
    end

    // Raise the selected valids and drop each after its handshake edge.
    task automatic hs(input bit aw, input bit w, input bit ar);
        bit pa, pw, pr, ha, hw, hr;
        int n;
        pa = aw; pw = w; pr = ar; n = 0;
        s_awvalid = aw; s_wvalid = w; s_arvalid = ar;
        while ((pa || pw || pr) && n < 20) begin
            @(negedge clk);
            ha = s_awvalid && s_awready;
            hw = s_wvalid && s_wready;
            hr = s_arvalid && s_arready;
            @(posedge clk);
            #1;
            if (ha) begin s_awvalid = 1'b0; pa = 1'b0; end
            if (hw) begin s_wvalid = 1'b0; pw = 1'b0; end
            if (hr) begin s_arvalid = 1'b0; pr = 1'b0; end
            n++;
        end
        if (pa || pw || pr) begin
            chk("hs_timeout", {29'd0, pa, pw, pr}, 32'd0);
            s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        cmd_q.push_back({1'b1, a[11:2], s, d});
        b_q.push_back(2'b00);
        hs(1, 1, 0);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp);
        s_araddr = a;
        cmd_q.push_back({1'b0, a[11:2], 4'h0, 32'h0});
        r_q.push_back(exp);
        hs(0, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        bram_dout = 32'h0;
        rst_n = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_araddr = '0; s_arvalid = 1'b0;
        s_bready = 1'b1; s_rready = 1'b1;
        idle(2);

        // reset values
        chk("rst_bvalid", {31'd0, s_bvalid}, 32'd0);
        chk("rst_rvalid", {31'd0, s_rvalid}, 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
        chk("rst_resp", {28'd0, s_bresp, s_rresp}, 32'd0);
        chk("rst_bram", {bram_en, bram_we, bram_wstrb, bram_addr},
            32'd0);
        chk("rst_bram_din", bram_din, 32'd0);
        chk("rst_ready", {29'd0, s_awready, s_wready, s_arready}, 32'd7);
        rst_n = 1'b1;
        idle(1);

        // 1: full write, bram write next cycle, bvalid the cycle after
        wr(12'h004, 32'hDEADBEEF, 4'hF);
        chk("t1_en_we", {30'd0, bram_en, bram_we}, 32'd3);
        chk("t1_addr", {22'd0, bram_addr}, 32'd1);
        idle(1);
        chk("t1_bvalid", {31'd0, s_bvalid}, 32'd1);
        chk("t1_en_once", {31'd0, bram_en}, 32'd0);
        idle(2);

        // 2: read back, rvalid two cycles after acceptance
        rd(12'h004, 32'hDEADBEEF);
        chk("t2_rvalid_early", {31'd0, s_rvalid}, 32'd0);
        idle(1);
        chk("t2_rvalid", {31'd0, s_rvalid}, 32'd1);
        chk("t2_rdata", s_rdata, 32'hDEADBEEF);
        idle(2);

        // 3: W leads AW by three cycles, partial strobes
        s_wdata = 32'h11223344; s_wstrb = 4'h3;
        hs(0, 1, 0);
        repeat (3) begin
            @(negedge clk);
            chk("t3_no_bram", {31'd0, bram_en}, 32'd0);
            chk("t3_w_held", {30'd0, s_awready, s_wready}, 32'd2);
            @(posedge clk);
            #1;
        end
        s_awaddr = 12'h008;
        cmd_q.push_back({1'b1, 10'd2, 4'h3, 32'h11223344});
        b_q.push_back(2'b00);
        hs(1, 0, 0);
        chk("t3_wstrb", {28'd0, bram_wstrb}, 32'd3);
        idle(3);
        rd(12'h008, 32'h00003344);
        idle(3);

        // zero strobes still write (no change) and answer OKAY
        wr(12'h004, 32'hFFFFFFFF, 4'h0);
        idle(3);
        rd(12'h004, 32'hDEADBEEF);
        idle(3);

        // only AW held: reads are not blocked
        s_awaddr = 12'h010;
        hs(1, 0, 0);
        rd(12'h004, 32'hDEADBEEF);
        idle(3);
        s_wdata = 32'h55667788; s_wstrb = 4'hF;
        cmd_q.push_back({1'b1, 10'd4, 4'hF, 32'h55667788});
        b_q.push_back(2'b00);
        hs(0, 1, 0);
        idle(3);
        rd(12'h010, 32'h55667788);
        idle(3);

        // 4: W held, AW and AR together -> write first, then read
        s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF;
        hs(0, 1, 0);
        s_awaddr = 12'h00C; s_araddr = 12'h00C;
        cmd_q.push_back({1'b1, 10'd3, 4'hF, 32'hCAFEF00D});
        cmd_q.push_back({1'b0, 10'd3, 4'h0, 32'h0});
        b_q.push_back(2'b00);
        r_q.push_back(32'hCAFEF00D);
        hs(1, 0, 1);
        idle(4);

        // 5: R back-pressure for five cycles
        s_rready = 1'b0;
        rd(12'h008, 32'h00003344);
        idle(1);
        s_araddr = 12'h000; s_arvalid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t5_rvalid", {31'd0, s_rvalid}, 32'd1);
            chk("t5_rdata", s_rdata, 32'h00003344);
            chk("t5_arready", {31'd0, s_arready}, 32'd0);
            chk("t5_no_bram", {31'd0, bram_en}, 32'd0);
            @(posedge clk);
            #1;
        end
        s_arvalid = 1'b0;
        s_rready = 1'b1;
        idle(3);

        // 6: reset during RD_WAIT drops the read and a held AW
        s_awaddr = 12'h020;
        hs(1, 0, 0);
        s_araddr = 12'h004;
        cmd_q.push_back({1'b0, 10'd1, 4'h0, 32'h0});
        hs(0, 0, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rvalid", {31'd0, s_rvalid}, 32'd0);
        chk("t6_bvalid", {31'd0, s_bvalid}, 32'd0);
        chk("t6_ready", {29'd0, s_awready, s_wready, s_arready}, 32'd7);
        idle(2);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t6_no_stale_r", {31'd0, s_rvalid}, 32'd0);
            chk("t6_aw_dropped", {31'd0, s_awready}, 32'd1);
        end
        idle(2);

        chk("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
        chk("b_q_empty", 32'(b_q.size()), 32'd0);
        chk("r_q_empty", 32'(r_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
